shift_exec_stage: RTL and testbench

// - Execute-stage pipeline wrapper around the combinational shift_unit for the 16-bit RISC core.
// - Consumes shift ops from decode over valid/ready; registers operands (S1), shifts, registers result (S2).
// - Hands result and destination tag to writeback over valid/ready.
// - Exports an in-flight destination mask for the decode interlock, plus a completed-op counter.

---
 rtl/shift_exec_stage_pkg.sv | 14 +
 rtl/shift_unit.sv | 23 ++
 rtl/shift_exec_stage.sv | 137 +++++++++++++
 tb/tb_shift_exec_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_exec_stage_pkg.sv
// Shared core constants and the shift-direction encoding used by decode and execute.
package shift_exec_stage_pkg;

    localparam int unsigned CPU_DATA_W = 16;
    localparam int unsigned CPU_AMT_W  = 4;
    localparam int unsigned CPU_RD_W   = 3;
    localparam int unsigned CPU_CNT_W  = 16;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_e;

endpackage

// File: rtl/shift_unit.sv
// Combinational logical shifter: zero fill in both directions, no carry out.
module shift_unit
    import shift_exec_stage_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned AMT_W  = CPU_AMT_W
) (
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amount,
    input  shift_dir_e        dir,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        if (dir == SHIFT_RIGHT) begin
            result = data >> amount;
        end else begin
            result = data << amount;
        end
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage execute wrapper: S1 operand regs -> shift_unit -> S2 result regs, valid/ready on both sides.
module shift_exec_stage
    import shift_exec_stage_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned AMT_W  = CPU_AMT_W,
    parameter int unsigned RD_W   = CPU_RD_W,
    parameter int unsigned CNT_W  = CPU_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [AMT_W-1:0]     in_amount,
    input  logic                 in_lorr,
    input  logic [RD_W-1:0]      in_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [RD_W-1:0]      out_rd,
    output logic                 out_zero,
    output logic [2**RD_W-1:0]   busy_mask,
    output logic [CNT_W-1:0]     op_count
);

    if (DATA_W != 16) begin : g_bad_data_w
        $error("shift_exec_stage: DATA_W must be 16");
    end

    logic               s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]  s1_data_q,  s1_data_d;
    logic [AMT_W-1:0]   s1_amt_q,   s1_amt_d;
    shift_dir_e         s1_dir_q,   s1_dir_d;
    logic [RD_W-1:0]    s1_rd_q,    s1_rd_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q,  out_data_d;
    logic [RD_W-1:0]    out_rd_q,    out_rd_d;
    logic               out_zero_q,  out_zero_d;
    logic [CNT_W-1:0]   op_count_q,  op_count_d;

    logic               s2_load;
    logic               in_fire;
    logic               out_fire;
    logic [DATA_W-1:0]  shift_res;

    shift_unit #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_shift (
        .data   (s1_data_q),
        .amount (s1_amt_q),
        .dir    (s1_dir_q),
        .result (shift_res)
    );

    always_comb begin
        s2_load  = s1_valid_q && (!out_valid_q || out_ready);
        in_ready = !flush && (!s1_valid_q || s2_load);
        in_fire  = in_valid && in_ready;
        out_fire = out_valid_q && out_ready;

        s1_valid_d = in_fire || (s1_valid_q && !s2_load);
        s1_data_d  = s1_data_q;
        s1_amt_d   = s1_amt_q;
        s1_dir_d   = s1_dir_q;
        s1_rd_d    = s1_rd_q;
        if (in_fire) begin
            s1_data_d = in_data;
            s1_amt_d  = in_amount;
            s1_dir_d  = shift_dir_e'(in_lorr);
            s1_rd_d   = in_rd;
        end

        out_valid_d = s2_load || (out_valid_q && !out_ready);
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_zero_d  = out_zero_q;
        if (s2_load) begin
            out_data_d = shift_res;
            out_rd_d   = s1_rd_q;
            out_zero_d = (shift_res == '0);
        end

        // Flush only kills the valid flags; a handshake on the same edge still counts.
        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end

        op_count_d = out_fire ? op_count_q + CNT_W'(1) : op_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_amt_q    <= '0;
            s1_dir_q    <= SHIFT_LEFT;
            s1_rd_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_zero_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_amt_q    <= s1_amt_d;
            s1_dir_q    <= s1_dir_d;
            s1_rd_q     <= s1_rd_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_zero_q  <= out_zero_d;
            op_count_q  <= op_count_d;
        end
    end

    always_comb begin
        busy_mask = '0;
        if (s1_valid_q) begin
            busy_mask[s1_rd_q] = 1'b1;
        end
        if (out_valid_q) begin
            busy_mask[out_rd_q] = 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;
    assign out_zero  = out_zero_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage: queue-based reference model checked every cycle plus directed literal checks.
module tb_shift_exec_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_amount;
    logic        in_lorr;
    logic [2:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_rd;
    logic        out_zero;
    logic [7:0]  busy_mask;
    logic [15:0] op_count;

    shift_exec_stage #(
        .DATA_W (16),
        .AMT_W  (4),
        .RD_W   (3),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amount (in_amount),
        .in_lorr   (in_lorr),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_zero  (out_zero),
        .busy_mask (busy_mask),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference shift in plain arithmetic: multiply/divide by 2**amount.
    function automatic logic [15:0] shift_model(logic [15:0] d, logic [3:0] a, logic right);
        longint unsigned p;
        longint unsigned v;
        p = 1;
        for (int i = 0; i < int'(a); i++) p = p * 2;
        if (right) v = longint'(d) / p;
        else       v = (longint'(d) * p) % 65536;
        return 16'(v);
    endfunction

    typedef struct {
        logic [15:0] data;
        logic [2:0]  rd;
        int unsigned age;
    } item_t;

    item_t       mq[$];
    logic [15:0] mcnt;
    bit          model_on = 1'b0;
    logic [15:0] got[$];
    bit          got_z[$];

    // Model: ops in flight form a FIFO of at most two; the head is presented once it has aged one edge.
    always begin : monitor
        logic [7:0]  exp_busy;
        logic        exp_ov;
        logic        exp_ir;
        logic        s_in, s_out, s_fl, s_rst, s_lorr;
        logic [15:0] s_data;
        logic [3:0]  s_amt;
        logic [2:0]  s_rd;
        @(negedge clk);
        if (model_on) begin
            exp_busy = '0;
            foreach (mq[i]) exp_busy[mq[i].rd] = 1'b1;
            exp_ov = (mq.size() > 0) && (mq[0].age >= 1);
            exp_ir = !flush && ((mq.size() < 2) || out_ready);
            check("busy_mask", 32'(busy_mask), 32'(exp_busy));
            check("op_count",  32'(op_count),  32'(mcnt));
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            check("in_ready",  32'(in_ready),  32'(exp_ir));
            if (exp_ov && out_valid === 1'b1) begin
                check("out_data", 32'(out_data), 32'(mq[0].data));
                check("out_rd",   32'(out_rd),   32'(mq[0].rd));
                check("out_zero", 32'(out_zero), 32'(mq[0].data == 16'h0000));
            end
        end
        s_in   = in_valid && in_ready;
        s_out  = out_valid && out_ready;
        s_fl   = flush;
        s_rst  = rst_n;
        s_data = in_data;
        s_amt  = in_amount;
        s_lorr = in_lorr;
        s_rd   = in_rd;
        @(posedge clk);
        if (s_rst !== 1'b1) begin
            mq.delete();
            mcnt     = '0;
            model_on = 1'b1;
        end else if (model_on) begin
            foreach (mq[i]) mq[i].age++;
            if (s_out === 1'b1) begin
                got.push_back(mq[0].data);
                got_z.push_back(mq[0].data == 16'h0000);
                void'(mq.pop_front());
                mcnt = mcnt + 16'd1;
            end
            if (s_fl) mq.delete();
            else if (s_in === 1'b1) mq.push_back('{shift_model(s_data, s_amt, s_lorr), s_rd, 0});
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] d, input logic [3:0] a, input logic r,
                        input logic [2:0] rd, output int unsigned stalls);
        bit ok;
        int unsigned n;
        in_valid  = 1'b1;
        in_data   = d;
        in_amount = a;
        in_lorr   = r;
        in_rd     = rd;
        stalls    = 0;
        n         = 0;
        ok        = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = (in_ready === 1'b1);
            if (!ok) stalls++;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("send_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (mq.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 32'(mq.size()), 32'(0));
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned st;
        int unsigned stall_total;
        int unsigned need;
        logic [15:0] cnt_before;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hDEAD;
        in_amount = 4'd3;
        in_lorr   = 1'b0;
        in_rd     = 3'd6;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready",  32'(in_ready),  32'(1));
        check("rst_op_count",  32'(op_count),  32'(0));
        check("rst_busy_mask", 32'(busy_mask), 32'(0));
        @(posedge clk);
        #1;

        // Single op, two-edge latency
        send(16'h8001, 4'd1, 1'b0, 3'd3, st);
        @(negedge clk);
        check("single_busy", 32'(busy_mask), 32'h08);
        check("single_not_yet", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("single_valid", 32'(out_valid), 32'(1));
        check("single_data",  32'(out_data),  32'h0002);
        check("single_rd",    32'(out_rd),    32'(3));
        check("single_zero",  32'(out_zero),  32'(0));
        check("single_busy2", 32'(busy_mask), 32'h08);
        @(posedge clk);
        #1;
        drain();

        // Stream with three cycles of backpressure
        got.delete();
        got_z.delete();
        stall_total = 0;
        fork
            begin
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            begin
                send(16'hF000, 4'd4, 1'b1, 3'd1, st); stall_total += st;
                send(16'h00FF, 4'd8, 1'b0, 3'd2, st); stall_total += st;
                send(16'h1234, 4'd0, 1'b0, 3'd4, st); stall_total += st;
            end
        join
        drain();
        check("bp_stalled", 32'(stall_total > 0), 32'(1));
        check("bp_count", 32'(got.size()), 32'(3));
        if (got.size() == 3) begin
            check("bp_item0", 32'(got[0]), 32'h0F00);
            check("bp_item1", 32'(got[1]), 32'hFF00);
            check("bp_item2", 32'(got[2]), 32'h1234);
        end

        // Zero result and amount boundaries
        got.delete();
        got_z.delete();
        send(16'h0001, 4'd1,  1'b1, 3'd0, st);
        send(16'h8000, 4'd15, 1'b1, 3'd5, st);
        send(16'hFFFF, 4'd15, 1'b0, 3'd7, st);
        drain();
        check("bnd_count", 32'(got.size()), 32'(3));
        if (got.size() == 3) begin
            check("bnd_zero_data", 32'(got[0]),   32'h0000);
            check("bnd_zero_flag", 32'(got_z[0]), 32'(1));
            check("bnd_r15",       32'(got[1]),   32'h0001);
            check("bnd_r15_zero",  32'(got_z[1]), 32'(0));
            check("bnd_l15",       32'(got[2]),   32'h8000);
        end

        // Flush with both stages full and writeback stalled
        out_ready = 1'b0;
        send(16'h0003, 4'd2, 1'b0, 3'd1, st);
        send(16'h0030, 4'd1, 1'b1, 3'd2, st);
        @(negedge clk);
        check("fl_busy_full", 32'(busy_mask), 32'h06);
        check("fl_full_ready", 32'(in_ready), 32'(0));
        cnt_before = mcnt;
        @(posedge clk);
        #1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h5555;
        in_amount = 4'd1;
        in_lorr   = 1'b0;
        in_rd     = 3'd5;
        @(negedge clk);
        check("fl_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("fl_out_valid", 32'(out_valid), 32'(0));
        check("fl_busy",      32'(busy_mask), 32'(0));
        check("fl_count",     32'(op_count),  32'(cnt_before));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        got.delete();
        got_z.delete();
        send(16'h0001, 4'd4, 1'b0, 3'd7, st);
        drain();
        check("fl_after_count", 32'(got.size()), 32'(1));
        if (got.size() == 1) check("fl_after_data", 32'(got[0]), 32'h0010);

        // Counter wrap
        need = 32'd65535 - 32'(mcnt);
        for (int unsigned i = 0; i < need; i++) begin
            send(16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 3'($urandom), st);
        end
        drain();
        @(negedge clk);
        check("wrap_max", 32'(op_count), 32'hFFFF);
        @(posedge clk);
        #1;
        send(16'h0100, 4'd2, 1'b1, 3'd2, st);
        drain();
        @(negedge clk);
        check("wrap_zero", 32'(op_count), 32'h0000);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
